// File: rtl/srlc_fifo_pkg.sv
// rtl/srlc_fifo_pkg.sv - shared constants and sizing helpers for the SRL-based FIFO
package srlc_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;
  localparam int unsigned LEVEL_W        = DEF_ADDR_WIDTH + 1;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/srl_storage.sv
// rtl/srl_storage.sv - bank of addressable shift-register lanes, one lane per data bit
module srl_storage
  import srlc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned L_DEPTH = fifo_depth(ADDR_WIDTH);

  // No reset on the lanes so each one can map onto a single SRL primitive.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    logic [L_DEPTH-1:0] r_sr;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        r_sr <= {r_sr[L_DEPTH-2:0], wr_data[g]};
      end
    end

    assign rd_data[g] = r_sr[addr];
  end

endmodule

// File: rtl/srlc_fifo.sv
// rtl/srlc_fifo.sv - shallow elastic FIFO on SRL storage with a registered output stage
module srlc_fifo
  import srlc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned         L_DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(L_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_FULL  = C_DEPTH + (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;

  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_out_free;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_tap;
  logic [ADDR_WIDTH:0]   w_level;

  assign w_s_ready  = (r_count < C_DEPTH);
  assign w_push     = s_valid && w_s_ready;
  assign w_out_free = !r_m_valid || m_ready;
  assign w_load     = w_out_free && (r_count != '0);
  // Oldest word sits at tap count-1; the value at count==0 is never used.
  assign w_addr     = r_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  srl_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_data (s_data),
    .addr    (w_addr),
    .rd_data (w_tap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (flush) begin
      r_count   <= '0;
      r_m_valid <= 1'b0;
    end else begin
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_m_data  <= w_tap;
        r_m_valid <= 1'b1;
      end else if (w_out_free) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign w_level = r_count + (ADDR_WIDTH + 1)'(r_m_valid);

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign level   = w_level;
  assign full    = (w_level == C_FULL);
  assign empty   = (w_level == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == C_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_load && (r_count == '0)));

endmodule

// File: tb/tb_srlc_fifo.sv
// tb/tb_srlc_fifo.sv - directed self-checking bench for srlc_fifo
module tb_srlc_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [5:0] level;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  srlc_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (level !== 6'd0)  begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 8'hA5;
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (level !== 6'd1)   begin errors++; $display("FAIL single_level1 got %0d want 1", level); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", m_valid); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", m_valid); end
    checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", m_data); end
    checks++; if (level !== 6'd1)   begin errors++; $display("FAIL single_level2 got %0d want 1", level); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (level !== 6'd0)   begin errors++; $display("FAIL single_drained_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL single_drained_empty got %b want 1", empty); end
  endtask

  task automatic test_fill_backpressure();
    int exp;
    m_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_s_ready_%0d got %b want 1", i, s_ready); end
      s_valid = 1'b1; s_data = 8'(i);
      @(negedge clk);
    end
    s_data = 8'hEE;
    checks++; if (level !== 6'd33)  begin errors++; $display("FAIL fill_level got %0d want 33", level); end
    checks++; if (full !== 1'b1)    begin errors++; $display("FAIL fill_full got %b want 1", full); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready_full got %b want 0", s_ready); end
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (level !== 6'd33)  begin errors++; $display("FAIL fill_overoffer_level got %0d want 33", level); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL fill_head got %h want 00", m_data); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready got %b want 1", s_ready); end
    checks++; if (level !== 6'd32)  begin errors++; $display("FAIL bp_level got %0d want 32", level); end
    checks++; if (m_data !== 8'h01) begin errors++; $display("FAIL bp_head got %h want 01", m_data); end
    s_valid = 1'b1; s_data = 8'h21;
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (level !== 6'd33)  begin errors++; $display("FAIL bp_refill_level got %0d want 33", level); end
    checks++; if (full !== 1'b1)    begin errors++; $display("FAIL bp_refill_full got %b want 1", full); end
    exp = 1;
    for (int k = 0; k < 60; k++) begin
      if (m_valid) begin
        checks++; if (m_data !== 8'(exp)) begin errors++; $display("FAIL fill_drain got %h want %h", m_data, 8'(exp)); end
        exp++;
      end else if (empty) begin
        break;
      end
      m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks++; if (exp !== 34)     begin errors++; $display("FAIL fill_drain_count got %0d want 34", exp); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    int exp;
    exp = 0;
    for (int c = 0; c < 100; c++) begin
      if (c >= 2) begin
        checks++; if (m_valid !== 1'b1)    begin errors++; $display("FAIL stream_valid c=%0d got %b want 1", c, m_valid); end
        checks++; if (m_data !== 8'(exp))  begin errors++; $display("FAIL stream_data c=%0d got %h want %h", c, m_data, 8'(exp)); end
        checks++; if (level !== 6'd2)      begin errors++; $display("FAIL stream_level c=%0d got %0d want 2", c, level); end
        exp++;
      end
      s_valid = 1'b1; s_data = 8'(c); m_ready = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m_valid) begin
        checks++; if (m_data !== 8'(exp)) begin errors++; $display("FAIL stream_tail got %h want %h", m_data, 8'(exp)); end
        exp++;
      end else if (empty) begin
        break;
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks++; if (exp !== 100)    begin errors++; $display("FAIL stream_count got %0d want 100", exp); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b want 1", empty); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h40 + i);
      @(negedge clk);
    end
    checks++; if (level !== 6'd10) begin errors++; $display("FAIL flush_pre_level got %0d want 10", level); end
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    checks++; if (level !== 6'd0)   begin errors++; $display("FAIL flush_level got %0d want 0", level); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got %b want 0", m_valid); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL flush_empty got %b want 1", empty); end
    s_valid = 1'b1; s_data = 8'h55;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL flush_after_valid got %b want 1", m_valid); end
    checks++; if (m_data !== 8'h55) begin errors++; $display("FAIL flush_after_data got %h want 55", m_data); end
    checks++; if (level !== 6'd1)   begin errors++; $display("FAIL flush_after_level got %0d want 1", level); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL flush_final_empty got %b want 1", empty); end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h90 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++; if (level !== 6'd5) begin errors++; $display("FAIL areset_pre_level got %0d want 5", level); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL areset_m_valid got %b want 0", m_valid); end
    checks++; if (level !== 6'd0)   begin errors++; $display("FAIL areset_level got %0d want 0", level); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL areset_empty got %b want 1", empty); end
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h3C;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL areset_first_valid got %b want 1", m_valid); end
    checks++; if (m_data !== 8'h3C) begin errors++; $display("FAIL areset_first_data got %h want 3c", m_data); end
    checks++; if (level !== 6'd1)   begin errors++; $display("FAIL areset_first_level got %0d want 1", level); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL areset_final_empty got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srlc_fifo.md
Name: srlc_fifo

Overview:
- Synchronous FIFO whose storage is a bank of addressable shift-register lanes.
- Writes shift each new word into tap 0. The reader recovers the oldest word by driving the tap address to occupancy-1.
- A registered output stage presents the head word with a valid/ready handshake.
- Sits between stream producers and consumers in the datapath wherever a shallow, LUT-cheap elastic buffer is needed.

Parameters:
- DATA_WIDTH, 8, bits per word; one shift-register lane per bit.
- ADDR_WIDTH, 5, tap address width; storage depth DEPTH = 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all contents.
- s_valid  input  1  write word offered.
- s_ready  output  1  storage can accept a word.
- s_data  input  DATA_WIDTH  write word.
- m_valid  output  1  head word valid.
- m_ready  input  1  consumer takes head word.
- m_data  output  DATA_WIDTH  head word, registered.
- level  output  ADDR_WIDTH+1  total words held (storage + output register), 0..DEPTH+1.
- full  output  1  level == DEPTH+1.
- empty  output  1  level == 0.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: count=0, m_valid=0, m_data=0, level=0, full=0, empty=1, s_ready=1. Shift-register contents are not reset.
- Internal count (ADDR_WIDTH+1 bits, 0..DEPTH) tracks words held in storage only.
- push = s_valid && s_ready. s_ready = (count < DEPTH), combinational from count only, independent of m_ready.
- On push, every lane shifts by one and s_data enters tap 0. Entry k holds the (k+1)-th newest word.
- Tap address = count-1 when count>0, otherwise don't-care. Read is combinational from pre-shift contents.
- out_free = !m_valid || m_ready.
- load = out_free && count>0.
  - On load: m_data <= tap word, m_valid <= 1.
  - If out_free and count==0: m_valid <= 0.
- count update:
  - push && !load: +1
  - load && !push: -1
  - both or neither: unchanged.
  - Simultaneous push/load is legal at any count, including count==DEPTH with m_ready=1. In that case s_ready=0, so no push occurs and the load frees one slot for the next cycle.
- Latency: a word pushed into an empty FIFO reaches m_valid at the second rising edge after acceptance (storage, then output register). No fall-through bypass.
- Ordering: strict FIFO. No reordering, no duplication, no loss except on flush.
- m_data holds stable while m_valid && !m_ready.
- flush has priority over push and load:
  - Next state: count=0, m_valid=0.
  - A word accepted in the flush cycle is discarded.
  - m_data value after flush is don't-care.
- level = count + m_valid, registered-equivalent (derived from registers only). full and empty are decoded from level.
- Async reset mid-transfer: all state is cleared immediately. No partial word appears after deassertion.
- Overflow and underflow are impossible by construction. Assertions: never push at count==DEPTH; never load at count==0.

Decomposition:
- Shared package constants:
  - DEPTH = 2**ADDR_WIDTH.
  - LEVEL_W = ADDR_WIDTH+1.
- Sub-module srl_storage:
  - DATA_WIDTH parallel shift-register lanes with common wr_en and addr.
  - Combinational tap read.
  - No reset.
  - Maps to SRL primitives.
- Control (count, output register, flags) stays in srlc_fifo.

Test Plan:
- Reset then single word: push 0xA5 at cycle 0 -> m_valid rises after second edge with m_data=0xA5; level goes 0,1,1. After m_ready handshake: level=0, empty=1.
- Fill with m_ready=0: push 0x00..0x20 (33 words) -> s_ready drops after 33rd acceptance, level=33, full=1. A 34th offer is not accepted. Draining returns 0x00..0x20 in order.
- Streaming at full rate (s_valid=m_ready=1 for 100 cycles, incrementing data) -> one word out per cycle after 2-cycle fill, level stays constant, output sequence contiguous.
- Backpressure on full: at level 33, assert m_ready one cycle -> 0x00 consumed, s_ready=1 next cycle, next push accepted, level returns to 33.
- Flush with simultaneous push: level=10, flush=1 and s_valid=1 with 0x77 -> next cycle level=0, m_valid=0. 0x77 never appears at the output.
- Async reset mid-stream: rst_n low between edges at level=5 -> m_valid=0, level=0 immediately. After release, a push of 0x3C emerges as the first output.
